// File: rtl/addsub_iter_if.sv
// addsub_iter_if
//   Handshake and data bundle for the iterative adder/subtractor.
//   master : producer/consumer side (drives operands, accepts result)
//   slave  : addsub_iter side (accepts operands, presents result)
// Signals:
//   in_valid/in_ready   operand handshake
//   op1, op2, sub       operands and mode (sub=1 -> op1 - op2)
//   out_valid/out_ready result handshake
//   result              WIDTH-bit sum/difference
//   carry, overflow, zero  result flags
interface addsub_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op1, op2, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, op1, op2, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/addsub_iter.sv
// addsub_iter
//   Iterative WIDTH-bit adder/subtractor processing CHUNK bits per cycle,
//   LSB slice first, N = WIDTH/CHUNK cycles per operation.
//   Subtraction is op1 + ~op2 + 1 (carry-in preset to sub).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  addsub_iter_if.slave: in_valid/in_ready, op1, op2, sub,
//        out_valid/out_ready, result, carry, overflow, zero
// Configuration:
//   ADDSUB_ITER_FLAGS_EN  defined   -> carry/overflow/zero computed
//                         undefined -> flags tied to 0, flag logic omitted
module addsub_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    addsub_iter_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             sub_q;
    logic             cin_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] res_next;

    // Operands are shifted right each CALC cycle so the active slice is
    // always the low CHUNK bits; the result fills in from the top.
    always_comb begin
        b_slice   = sub_q ? ~b_q[CHUNK-1:0] : b_q[CHUNK-1:0];
        slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_slice} + {{CHUNK{1'b0}}, cin_q};
    end

    if (N > 1) begin : g_multi
        assign res_next = {slice_sum[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
    end else begin : g_single
        assign res_next = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sub_q       <= 1'b0;
            cin_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.op1;
                        b_q        <= bus.op2;
                        sub_q      <= bus.sub;
                        cin_q      <= bus.sub;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    cin_q <= slice_sum[CHUNK];
                    res_q <= res_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;

`ifdef ADDSUB_ITER_FLAGS_EN
    logic carry_q;
    logic ovf_q;
    logic zero_q;
    logic msb_cin;

    // Carry into the MSB recovered from the top bit of the final slice.
    assign msb_cin = a_q[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_sum[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state == CALC && cnt == LAST) begin
            carry_q <= slice_sum[CHUNK];
            ovf_q   <= msb_cin ^ slice_sum[CHUNK];
            zero_q  <= (res_next == '0);
        end
    end

    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
`else
    assign bus.carry    = 1'b0;
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
`endif
endmodule
